// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit accumulator ALU: opcodes, flag indices, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu4_pkg;

    localparam int W = 4;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Flag vector is {C,V,N,Z}
    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU (LOAD..SUB) assembled from nibble-wide gate cells and a ripple adder.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is used.
//
// Ports: a, b - operands; op - opcode; y - result; c - carry out of bit 3
//        (ADD/SUB only, else 0); v - signed overflow (ADD/SUB only, else 0).

module gate_and4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a & b;
endmodule

module gate_or4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a | b;
endmodule

module gate_xor4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a ^ b;
endmodule

module gate_xnor4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = ~(a ^ b);
endmodule

module gate_inv4 (
    input  logic [3:0] a,
    output logic [3:0] y
);
    assign y = ~a;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu4_core
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] y,
    output logic       c,
    output logic       v
);

    logic [3:0] and_y;
    logic [3:0] or_y;
    logic [3:0] xor_y;
    logic [3:0] xnor_y;
    logic [3:0] b_inv;
    logic [3:0] b_sel;
    logic [3:0] sum;
    logic [4:0] carry;
    logic       is_sub;

    gate_and4  u_and  (.a(a), .b(b), .y(and_y));
    gate_or4   u_or   (.a(a), .b(b), .y(or_y));
    gate_xor4  u_xor  (.a(a), .b(b), .y(xor_y));
    gate_xnor4 u_xnor (.a(a), .b(b), .y(xnor_y));
    gate_inv4  u_inv  (.a(b), .y(b_inv));

    // SUB reuses the adder as A + ~B + 1
    assign is_sub   = (op == OP_SUB);
    assign b_sel    = is_sub ? b_inv : b;
    assign carry[0] = is_sub;

    for (genvar i = 0; i < 4; i++) begin : g_rca
        full_adder u_fa (
            .a  (a[i]),
            .b  (b_sel[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        y = b;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_LOAD: y = b;
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            OP_XNOR: y = xnor_y;
            OP_ADD, OP_SUB: begin
                y = sum;
                c = carry[4];
                // overflow when carry into the sign bit differs from carry out
                v = carry[4] ^ carry[3];
            end
            default: y = b;
        endcase
    end

endmodule

// File: rtl/alu4_acc_unit.sv
// 4-bit accumulator stage: single-cycle logic/arith ops, 4-iteration shift-add MUL into acc_hi:acc.
// Latency: non-MUL commits at the accept edge; MUL commits 4 edges after accept.
// Backpressure: o_ready low while MUL iterates; commands offered then are dropped, not queued.
//
// Ports: clk, reset_n (async active-low); i_valid/i_op/i_operand - command;
//        o_ready - can accept; o_acc/o_acc_hi - result nibbles; o_flags - {C,V,N,Z};
//        o_done - one-cycle pulse per committed result.

module alu4_acc_unit
    import alu4_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [2:0] i_op,
    input  logic [3:0] i_operand,
    output logic       o_ready,
    output logic [3:0] o_acc,
    output logic [3:0] o_acc_hi,
    output logic [3:0] o_flags,
    output logic       o_done
);

    state_t     state;
    logic [3:0] acc;
    logic [3:0] acc_hi;
    logic [3:0] flags;
    logic       done;

    logic [3:0] mcand;
    logic [3:0] mplier;
    logic [7:0] partial;
    logic [1:0] cnt;

    logic [3:0] alu_y;
    logic       alu_c;
    logic       alu_v;
    logic [3:0] alu_flags;
    logic [7:0] mul_addend;
    logic [7:0] partial_nxt;
    logic [3:0] mul_flags;

    alu4_core u_core (
        .a  (acc),
        .b  (i_operand),
        .op (i_op),
        .y  (alu_y),
        .c  (alu_c),
        .v  (alu_v)
    );

    // The core already forces C and V to 0 for LOAD and logic ops
    always_comb begin
        alu_flags        = 4'b0000;
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_V] = alu_v;
        alu_flags[FLG_N] = alu_y[3];
        alu_flags[FLG_Z] = (alu_y == 4'h0);
    end

    // One shift-add step; on the cnt==3 edge this is the finished product
    always_comb begin
        mul_addend  = mplier[cnt] ? ({4'h0, mcand} << cnt) : 8'h00;
        partial_nxt = partial + mul_addend;
    end

    always_comb begin
        mul_flags        = 4'b0000;
        mul_flags[FLG_C] = (partial_nxt[7:4] != 4'h0);
        mul_flags[FLG_V] = 1'b0;
        mul_flags[FLG_N] = partial_nxt[7];
        mul_flags[FLG_Z] = (partial_nxt == 8'h00);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            acc     <= 4'h0;
            acc_hi  <= 4'h0;
            flags   <= 4'h0;
            done    <= 1'b0;
            mcand   <= 4'h0;
            mplier  <= 4'h0;
            partial <= 8'h00;
            cnt     <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (i_op == OP_MUL) begin
                            mcand   <= acc;
                            mplier  <= i_operand;
                            partial <= 8'h00;
                            cnt     <= 2'd0;
                            state   <= ST_MUL;
                        end else begin
                            acc    <= alu_y;
                            acc_hi <= 4'h0;
                            flags  <= alu_flags;
                            done   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    partial <= partial_nxt;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        acc    <= partial_nxt[3:0];
                        acc_hi <= partial_nxt[7:4];
                        flags  <= mul_flags;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready  = (state == ST_IDLE);
    assign o_acc    = acc;
    assign o_acc_hi = acc_hi;
    assign o_flags  = flags;
    assign o_done   = done;

endmodule
